// File: rtl/approx_mon_pkg.sv
// approx_mon_pkg
//   Shared types and width helpers for the approximate-multiplier error monitor.
//   mon_state_t     : window FSM states (accept, drain, report)
//   ed_width        : signed error-distance width for a WIDTH x WIDTH multiplier
//   sum_aed_width   : width of the windowed sum of |ED|
//   sum_ed_width    : width of the windowed signed sum of ED
//   cnt_width       : width of the per-window sample / error counters
package approx_mon_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } mon_state_t;

  function automatic int ed_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_aed_width(input int w, input int wl2);
    return 2 * w + wl2;
  endfunction

  function automatic int sum_ed_width(input int w, input int wl2);
    return 2 * w + wl2 + 1;
  endfunction

  function automatic int cnt_width(input int wl2);
    return wl2 + 1;
  endfunction

endpackage

// File: rtl/approx_ed_unit.sv
// approx_ed_unit
//   Combinational exact multiply and error distance for one GenMul sample.
//   a, b : operands given to the approximate multiplier
//   p    : approximate product it returned
//   ed   : signed error distance p - a*b (2*WIDTH+1 bits, two's complement)
//   aed  : |ed|, always representable in 2*WIDTH bits
module approx_ed_unit
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [2*WIDTH-1:0]       p,
  output logic signed [2*WIDTH:0] ed,
  output logic [2*WIDTH-1:0]       aed
);

  localparam int EW = ed_width(WIDTH);

  logic [2*WIDTH-1:0] exact;
  logic [EW-1:0]      ed_neg;

  always_comb begin
    exact  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // one extra bit so both operands are non-negative before subtracting
    ed     = $signed({1'b0, p}) - $signed({1'b0, exact});
    ed_neg = -ed;
    aed    = ed[EW-1] ? ed_neg[2*WIDTH-1:0] : ed[2*WIDTH-1:0];
  end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
//   Windowed error statistics for an approximate multiplier under evaluation.
//   clk, rst_n         : clock, async active-low reset
//   clear              : synchronous flush, restarts the window
//   in_valid/in_ready  : sample handshake (in_a, in_b, in_p)
//   res_valid/res_ready: per-window record handshake
//   res_sum_aed        : sum of |ED|      res_sum_ed : signed sum of ED
//   res_max_aed        : max |ED|         res_wce_a/b: operands of first max
//   res_err_cnt        : samples with ED != 0
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_ACCEPT  | taking samples until 2**WINDOW_LOG2 have been accepted
//   ST_DRAIN   | no new samples; waiting for S1/S2 to empty into S3
//   ST_REPORT  | record presented and held until res_ready
module approx_mul_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic [2*WIDTH-1:0]             in_p,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [2*WIDTH+WINDOW_LOG2-1:0] res_sum_aed,
  output logic [2*WIDTH+WINDOW_LOG2:0]   res_sum_ed,
  output logic [2*WIDTH-1:0]             res_max_aed,
  output logic [WIDTH-1:0]               res_wce_a,
  output logic [WIDTH-1:0]               res_wce_b,
  output logic [WINDOW_LOG2:0]           res_err_cnt
);

  localparam int CW = cnt_width(WINDOW_LOG2);
  localparam logic [CW-1:0] LAST = CW'((1 << WINDOW_LOG2) - 1);

  mon_state_t state;
  logic [CW-1:0] acc_cnt;
  logic          idle_q;
  logic          accept;
  logic          handshake;

  logic                   s1_v;
  logic [WIDTH-1:0]       s1_a, s1_b;
  logic [2*WIDTH-1:0]     s1_p;
  logic signed [2*WIDTH:0] ed_c;
  logic [2*WIDTH-1:0]     aed_c;

  logic                   s2_v;
  logic [WIDTH-1:0]       s2_a, s2_b;
  logic signed [2*WIDTH:0] s2_ed;
  logic [2*WIDTH-1:0]     s2_aed;

  // rst_n gates in_ready so it reads 0 while reset is held and 1 as soon as
  // it is released; idle_q inserts the one dead cycle after a record handshake
  assign in_ready  = rst_n && (state == ST_ACCEPT) && !idle_q;
  assign res_valid = (state == ST_REPORT);
  assign accept    = in_valid && in_ready;
  assign handshake = res_valid && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACCEPT;
      acc_cnt <= '0;
      idle_q  <= 1'b0;
    end else if (clear) begin
      state   <= ST_ACCEPT;
      acc_cnt <= '0;
      idle_q  <= 1'b0;
    end else begin
      idle_q <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == LAST) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!s1_v && !s2_v) state <= ST_REPORT;
        end
        ST_REPORT: begin
          if (res_ready) begin
            state   <= ST_ACCEPT;
            acc_cnt <= '0;
            idle_q  <= 1'b1;
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_p <= '0;
    end else begin
      s1_v <= accept && !clear;
      if (accept) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_p <= in_p;
      end
    end
  end

  approx_ed_unit #(.WIDTH(WIDTH)) u_ed (
    .a   (s1_a),
    .b   (s1_b),
    .p   (s1_p),
    .ed  (ed_c),
    .aed (aed_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_ed  <= '0;
      s2_aed <= '0;
    end else begin
      s2_v <= s1_v && !clear;
      if (s1_v) begin
        s2_a   <= s1_a;
        s2_b   <= s1_b;
        s2_ed  <= ed_c;
        s2_aed <= aed_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_aed <= '0;
      res_sum_ed  <= '0;
      res_max_aed <= '0;
      res_wce_a   <= '0;
      res_wce_b   <= '0;
      res_err_cnt <= '0;
    end else if (clear || handshake) begin
      res_sum_aed <= '0;
      res_sum_ed  <= '0;
      res_max_aed <= '0;
      res_wce_a   <= '0;
      res_wce_b   <= '0;
      res_err_cnt <= '0;
    end else if (s2_v) begin
      res_sum_aed <= res_sum_aed + {{WINDOW_LOG2{1'b0}}, s2_aed};
      res_sum_ed  <= res_sum_ed + {{WINDOW_LOG2{s2_ed[2*WIDTH]}}, s2_ed};
      res_err_cnt <= res_err_cnt + {{WINDOW_LOG2{1'b0}}, (s2_ed != '0)};
      // strict compare: the earliest sample keeps a tie
      if (s2_aed > res_max_aed) begin
        res_max_aed <= s2_aed;
        res_wce_a   <= s2_a;
        res_wce_b   <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
module tb_approx_mul_err_monitor;

  localparam int W = 8;
  localparam int L = 2;
  localparam int N = 1 << L;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2*W-1:0] in_p = '0;
  logic in_ready, res_valid;
  logic [2*W+L-1:0] res_sum_aed;
  logic [2*W+L:0] res_sum_ed;
  logic [2*W-1:0] res_max_aed;
  logic [W-1:0] res_wce_a, res_wce_b;
  logic [L:0] res_err_cnt;

  approx_mul_err_monitor #(.WIDTH(W), .WINDOW_LOG2(L)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum_aed(res_sum_aed), .res_sum_ed(res_sum_ed),
    .res_max_aed(res_max_aed), .res_wce_a(res_wce_a),
    .res_wce_b(res_wce_b), .res_err_cnt(res_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum_aed;
    longint sum_ed;
    longint max_aed;
    longint wa;
    longint wb;
    longint cnt;
  } rec_t;

  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];
  int win_a[$], win_b[$], win_p[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: statistics straight from the window's sample list
  function automatic void model_push(input int a, input int b, input int p);
    rec_t r;
    longint ed, ae;
    win_a.push_back(a);
    win_b.push_back(b);
    win_p.push_back(p);
    if (win_a.size() == N) begin
      r = '{0, 0, 0, 0, 0, 0};
      for (int i = 0; i < N; i++) begin
        ed = longint'(win_p[i]) - longint'(win_a[i]) * longint'(win_b[i]);
        ae = (ed < 0) ? -ed : ed;
        r.sum_aed += ae;
        r.sum_ed  += ed;
        if (ed != 0) r.cnt++;
        if (ae > r.max_aed) begin
          r.max_aed = ae;
          r.wa = win_a[i];
          r.wb = win_b[i];
        end
      end
      exp_q.push_back(r);
      win_a.delete();
      win_b.delete();
      win_p.delete();
    end
  endfunction

  // Monitor: compares every record the DUT hands over against the scoreboard
  always @(negedge clk) begin
    rec_t r;
    #1;
    if (rst_n && !clear && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record actual=present required=none");
      end else begin
        r = exp_q.pop_front();
        chk("sum_aed", longint'(res_sum_aed), r.sum_aed);
        chk("sum_ed", longint'($signed(res_sum_ed)), r.sum_ed);
        chk("max_aed", longint'(res_max_aed), r.max_aed);
        chk("wce_a", longint'(res_wce_a), r.wa);
        chk("wce_b", longint'(res_wce_b), r.wb);
        chk("err_cnt", longint'(res_err_cnt), r.cnt);
      end
    end
  end

  task automatic send(input int a, input int b, input int p, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    in_p = (2*W)'(p);
    model_push(a, b, p);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take_record(input int delay);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      chk("res_valid_timeout", 0, 1);
      return;
    end
    repeat (delay) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("in_ready_after_hs", longint'(in_ready), 0);
    chk("res_valid_after_hs", longint'(res_valid), 0);
    @(negedge clk);
    chk("in_ready_idle_done", longint'(in_ready), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_res_valid"}, longint'(res_valid), 0);
    chk({tag, "_sum_aed"}, longint'(res_sum_aed), 0);
    chk({tag, "_sum_ed"}, longint'(res_sum_ed), 0);
    chk({tag, "_max_aed"}, longint'(res_max_aed), 0);
    chk({tag, "_wce"}, longint'({res_wce_a, res_wce_b}), 0);
    chk({tag, "_err_cnt"}, longint'(res_err_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, p, e, mode;

    // reset state
    #2;
    chk("reset_in_ready", longint'(in_ready), 0);
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", longint'(in_ready), 1);
    @(negedge clk);

    // 1: mixed window back-to-back, latency of 3 edges
    send(10, 10, 96, 0);
    send(200, 100, 20010, 0);
    send(1, 1, 1, 0);
    send(0, 0, 0, 0);
    chk("t1_in_ready_k", longint'(in_ready), 0);
    chk("t1_valid_k", longint'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_k1", longint'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_k2", longint'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_k3", longint'(res_valid), 1);
    take_record(0);

    // 2: worst negative error in every sample
    for (int i = 0; i < N; i++) send(255, 255, 0, 0);
    take_record(1);

    // 3: tie on |ED|, first sample keeps it
    send(3, 3, 14, 0);
    send(4, 4, 21, 0);
    send(7, 9, 63, 0);
    send(12, 5, 60, 0);
    take_record(0);

    // 4: backpressure in REPORT
    send(17, 3, 50, 0);
    send(100, 2, 210, 1);
    send(9, 9, 81, 0);
    send(250, 250, 62000, 2);
    begin
      int n = 0;
      while (!res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", longint'(res_valid), 1);
      chk("t4_hold_in_ready", longint'(in_ready), 0);
      if (exp_q.size() > 0) begin
        chk("t4_hold_sum_aed", longint'(res_sum_aed), exp_q[0].sum_aed);
        chk("t4_hold_max_aed", longint'(res_max_aed), exp_q[0].max_aed);
      end
      @(negedge clk);
    end
    take_record(0);
    send(2, 2, 5, 0);
    send(6, 6, 36, 0);
    send(8, 8, 60, 0);
    send(1, 200, 200, 0);
    take_record(0);

    // 5: clear after two accepts drops them
    send(255, 255, 0, 0);
    send(200, 200, 1, 0);
    clear = 1'b1;
    chk("t5_in_ready_clear", longint'(in_ready), 1);
    @(negedge clk);
    clear = 1'b0;
    win_a.delete();
    win_b.delete();
    win_p.delete();
    chk("t5_in_ready_after", longint'(in_ready), 1);
    send(5, 5, 24, 0);
    send(6, 7, 42, 0);
    send(11, 11, 125, 0);
    send(0, 9, 3, 0);
    take_record(0);

    // randomized windows
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < N; i++) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        mode = $urandom_range(0, 3);
        case (mode)
          0: p = a * b;
          1: begin
            e = a * b + $urandom_range(0, 16) - 8;
            p = (e < 0) ? 0 : (e > 65535) ? 65535 : e;
          end
          2: p = $urandom_range(0, 65535);
          default: p = (a * b) & 32'hFFF0;
        endcase
        send(a, b, p, $urandom_range(0, 2));
      end
      take_record($urandom_range(0, 3));
    end

    // 6: reset while a record is pending
    send(30, 30, 880, 0);
    send(2, 3, 7, 0);
    send(40, 1, 40, 0);
    send(255, 1, 0, 0);
    begin
      int n = 0;
      while (!res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_valid_before_rst", longint'(res_valid), 1);
    #2;
    rst_n = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
    chk("t6_in_ready_in_rst", longint'(in_ready), 0);
    check_zero_outputs("t6_in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready_after", longint'(in_ready), 1);
    check_zero_outputs("t6_after");
    @(negedge clk);

    send(1, 2, 3, 0);
    send(4, 4, 16, 0);
    send(255, 128, 32640, 0);
    send(9, 10, 80, 0);
    take_record(0);

    repeat (5) @(negedge clk);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
